display_reader: RTL and testbench

Receiving end of the seven-segment display path: samples the time-multiplexed, active-low segment and anode bus that drives the board's displays and reconstructs the BCD value of each digit. Each digit's pattern must stay stable for a configurable number of cycles before it is decoded and stored. The block sits beside the display driver, so the bench and on-chip self-check logic can read back what the processor actually put on the displays. Patterns outside the decimal set are flagged as errors.

---
 rtl/display_reader.sv | 125 ++++++++++++
 tb/tb_display_reader.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/display_reader.sv
// rtl/display_reader.sv - decodes a multiplexed active-low seven-segment bus back into per-digit BCD.
// Optional decimal-point capture is enabled by defining DISPLAY_READER_DP_EN.
module display_reader #(
  parameter int DIGITS = 4,
  parameter int SETTLE = 3,
  localparam int DW = (DIGITS > 2) ? $clog2(DIGITS) : 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [6:0]            Segmentos,
  input  logic [DIGITS-1:0]     Anodos,
`ifdef DISPLAY_READER_DP_EN
  input  logic                  Ponto,
  output logic [DIGITS-1:0]     Pontos,
`endif
  output logic [4*DIGITS-1:0]   Valor,
  output logic [DW-1:0]         Digito,
  output logic                  Valido,
  output logic                  Erro
);
  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

  state_t            r_state, w_state_nx;
  logic [DIGITS-1:0] r_an;
  logic [6:0]        r_seg;
  logic [CW-1:0]     r_cnt, w_cnt_nx;
  logic              w_onehot, w_same, w_capture, w_pat_ok;
  logic [3:0]        w_code;
  logic [DW-1:0]     w_idx;
`ifdef DISPLAY_READER_DP_EN
  logic              r_dp;
`endif

  // The pair being registered on this edge is compared with the pair already held.
  assign w_onehot = ($countones(~Anodos) == 1);
`ifdef DISPLAY_READER_DP_EN
  assign w_same = (Anodos == r_an) && (Segmentos == r_seg) && (Ponto == r_dp);
`else
  assign w_same = (Anodos == r_an) && (Segmentos == r_seg);
`endif

  always_comb begin
    w_pat_ok = 1'b1;
    w_code   = 4'hF;
    case (Segmentos)
      7'b0000001: w_code = 4'd0;
      7'b1001111: w_code = 4'd1;
      7'b0010010: w_code = 4'd2;
      7'b0000110: w_code = 4'd3;
      7'b1001100: w_code = 4'd4;
      7'b0100100: w_code = 4'd5;
      7'b0100000: w_code = 4'd6;
      7'b0001111: w_code = 4'd7;
      7'b0000000: w_code = 4'd8;
      7'b0001100: w_code = 4'd9;
      7'b1111111: w_code = 4'hF;
      default:    w_pat_ok = 1'b0;
    endcase
  end

  // Descending scan so the lowest low anode wins; only consulted when one-hot.
  always_comb begin
    w_idx = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (!Anodos[i]) w_idx = DW'(i);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_capture  = 1'b0;
    if (!w_onehot) begin
      w_state_nx = ST_IDLE;
      w_cnt_nx   = '0;
    end else if (!w_same) begin
      w_state_nx = ST_SETTLE;
      w_cnt_nx   = '0;
    end else if (r_state == ST_HOLD) begin
      w_cnt_nx   = CW'(SETTLE);
    end else if (r_cnt == CW'(SETTLE - 1)) begin
      w_state_nx = ST_HOLD;
      w_cnt_nx   = CW'(SETTLE);
      w_capture  = 1'b1;
    end else begin
      w_cnt_nx   = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_an    <= '1;
      r_seg   <= '1;
      Valor   <= '1;
      Digito  <= '0;
      Valido  <= 1'b0;
      Erro    <= 1'b0;
`ifdef DISPLAY_READER_DP_EN
      r_dp    <= 1'b1;
      Pontos  <= '0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_an    <= Anodos;
      r_seg   <= Segmentos;
      Valido  <= w_capture && w_pat_ok;
      Erro    <= w_capture && !w_pat_ok;
`ifdef DISPLAY_READER_DP_EN
      r_dp    <= Ponto;
`endif
      if (w_capture) begin
        Digito <= w_idx;
        if (w_pat_ok) Valor[4*w_idx +: 4] <= w_code;
`ifdef DISPLAY_READER_DP_EN
        Pontos[w_idx] <= ~Ponto;
`endif
      end
    end
  end
endmodule

// File: tb/tb_display_reader.sv
// tb/tb_display_reader.sv - scoreboard bench for display_reader (DIGITS=4, SETTLE=3).
// Decimal-point checks run when DISPLAY_READER_DP_EN is defined.
module tb_display_reader;
  localparam int DIGITS = 4;
  localparam int SETTLE = 3;
  localparam int K_NONE = 0, K_VAL = 1, K_ERR = 2;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [6:0]  Segmentos;
  logic [3:0]  Anodos;
  logic [15:0] Valor;
  logic [1:0]  Digito;
  logic        Valido, Erro;
`ifdef DISPLAY_READER_DP_EN
  logic        Ponto;
  logic [3:0]  Pontos;
`endif

  display_reader #(.DIGITS(DIGITS), .SETTLE(SETTLE)) dut (
    .Clock(Clock), .Reset(Reset), .Segmentos(Segmentos), .Anodos(Anodos),
`ifdef DISPLAY_READER_DP_EN
    .Ponto(Ponto), .Pontos(Pontos),
`endif
    .Valor(Valor), .Digito(Digito), .Valido(Valido), .Erro(Erro)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int          cyc;
    int          kind;
    int          dig;
    logic [15:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    if (Valido || Erro) begin
      exp_t e;
      check("pulse_exclusive", {31'd0, Valido && Erro}, 32'd0);
      if (q.size() == 0) begin
        check("unexpected_pulse", {30'd0, Erro, Valido}, 32'd0);
      end else begin
        e = q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_kind", Valido ? K_VAL : K_ERR, e.kind);
        check("digito", {30'd0, Digito}, e.dig);
        check("valor", {16'd0, Valor}, {16'd0, e.val});
      end
    end
  end

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n,
                      input int kind, input int dig, input logic [15:0] val);
    exp_t e;
    Anodos    = an;
    Segmentos = seg;
    if (kind != K_NONE) begin
      e.cyc  = cyc + SETTLE + 1;
      e.kind = kind;
      e.dig  = dig;
      e.val  = val;
      q.push_back(e);
    end
    repeat (n) @(negedge Clock);
  endtask

  initial begin
    Reset     = 1'b1;
    Anodos    = 4'hF;
    Segmentos = 7'h7F;
`ifdef DISPLAY_READER_DP_EN
    Ponto     = 1'b1;
`endif
    repeat (2) @(negedge Clock);
    check("rst_valor", {16'd0, Valor}, 32'hFFFF);
    check("rst_valido", {31'd0, Valido}, 32'd0);
    check("rst_erro", {31'd0, Erro}, 32'd0);
    check("rst_digito", {30'd0, Digito}, 32'd0);
`ifdef DISPLAY_READER_DP_EN
    check("rst_pontos", {28'd0, Pontos}, 32'd0);
`endif
    Reset = 1'b0;
    @(negedge Clock);

    hold(4'b1101, 7'b0010010, 8, K_VAL, 1, 16'hFF2F);
    hold(4'b1110, 7'b0000110, 6, K_VAL, 0, 16'hFF23);
    hold(4'b1101, 7'b0001111, 6, K_VAL, 1, 16'hFF73);
    hold(4'b1011, 7'b1111111, 6, K_VAL, 2, 16'hFF73);
    hold(4'b0111, 7'b0001100, 6, K_VAL, 3, 16'h9F73);
    hold(4'b1110, 7'b1010101, 5, K_ERR, 0, 16'h9F73);
    hold(4'b1011, 7'b0000000, 2, K_NONE, 0, 16'h0);
    hold(4'b1111, 7'b0000000, 3, K_NONE, 0, 16'h0);
    hold(4'b0011, 7'b0000000, 10, K_NONE, 0, 16'h0);
    hold(4'b0111, 7'b1001111, 6, K_VAL, 3, 16'h1F73);
    hold(4'b0111, 7'b0000001, 1, K_NONE, 0, 16'h0);
    hold(4'b0111, 7'b1001111, 6, K_VAL, 3, 16'h1F73);
    hold(4'b1111, 7'b1111111, 2, K_NONE, 0, 16'h0);

    // Reset lands on the edge that would capture.
    Anodos    = 4'b1110;
    Segmentos = 7'b0100100;
    repeat (3) @(negedge Clock);
    Reset  = 1'b1;
    Anodos = 4'hF;
    @(negedge Clock);
    check("rst_mid_valido", {31'd0, Valido}, 32'd0);
    check("rst_mid_valor", {16'd0, Valor}, 32'hFFFF);
    check("rst_mid_digito", {30'd0, Digito}, 32'd0);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);

`ifdef DISPLAY_READER_DP_EN
    Ponto = 1'b0;
    hold(4'b0111, 7'b0100100, 6, K_VAL, 3, 16'h5FFF);
    check("pontos", {28'd0, Pontos}, 32'h8);
    Ponto = 1'b1;
    hold(4'b1111, 7'b1111111, 2, K_NONE, 0, 16'h0);
`endif

    repeat (5) @(negedge Clock);
    check("missing_pulses", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
